// File: rtl/cache_2way_wb_if.sv
// CPU-side and memory-side bus bundle for cache_2way_wb.
// The slave modport is the cache's view: it serves CPU requests and
// masters the word-wide memory port. The master modport is the
// environment's view (CPU driver plus memory responder).
interface cache_2way_wb_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [AWIDTH-1:0] cpu_addr;
    logic [DWIDTH-1:0] cpu_wdata;
    logic [DWIDTH-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_busy;

    logic              mem_req;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_busy,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_busy,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cache_2way_wb.sv
// Two-way set-associative write-back / write-allocate cache controller.
// Address split {tag, index, offset}; line fills and write-backs run as
// per-beat handshaked bursts. One idle cycle separates LOOKUP from the
// first beat; a write-back flows straight into the fill burst.
// Optional feature: define CACHE_PERF_CNT_EN to get hit/miss counters;
// otherwise hit_count/miss_count are tied to zero.
module cache_2way_wb #(
    parameter int AWIDTH    = 16,
    parameter int DWIDTH    = 8,
    parameter int BLOCKSIZE = 4,
    parameter int NUMSETS   = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    cache_2way_wb_if.slave      bus,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);
    localparam int OFFW = $clog2(BLOCKSIZE);
    localparam int IDXW = $clog2(NUMSETS);
    localparam int TAGW = AWIDTH - OFFW - IDXW;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

    // Storage arrays
    logic [DWIDTH-1:0]  data_q  [2][NUMSETS][BLOCKSIZE];
    logic [TAGW-1:0]    tag_q   [2][NUMSETS];
    logic [NUMSETS-1:0] valid_q [2];
    logic [NUMSETS-1:0] valid_d [2];
    logic [NUMSETS-1:0] dirty_q [2];
    logic [NUMSETS-1:0] dirty_d [2];
    logic [NUMSETS-1:0] lru_q, lru_d;       // way that is least recently used

    // Control and output registers
    state_t             state_q, state_d;
    logic [OFFW-1:0]    beat_q, beat_d;
    logic               victim_q, victim_d;
    logic               req_we_q, req_we_d;
    logic [AWIDTH-1:0]  req_addr_q, req_addr_d;
    logic [DWIDTH-1:0]  req_wdata_q, req_wdata_d;
    logic [DWIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               cpu_busy_q, cpu_busy_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [AWIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]  mem_wdata_q, mem_wdata_d;

    // Storage write controls
    logic               dwr_en;
    logic               dwr_way;
    logic [OFFW-1:0]    dwr_ofs;
    logic [DWIDTH-1:0]  dwr_val;
    logic               tag_wr;
    logic               hit_evt, miss_evt;

    // Request address fields
    logic [TAGW-1:0]    req_tag;
    logic [IDXW-1:0]    req_idx;
    logic [OFFW-1:0]    req_off;
    logic               hit0, hit1, hit_way, vsel;
    logic               beat_done, last_beat;
    logic [OFFW-1:0]    beat_nxt;
    logic [TAGW-1:0]    victim_tag;

    assign req_tag    = req_addr_q[AWIDTH-1 -: TAGW];
    assign req_idx    = req_addr_q[OFFW +: IDXW];
    assign req_off    = req_addr_q[OFFW-1:0];
    assign hit0       = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1       = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit_way    = !hit0;
    assign vsel       = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    assign beat_done  = mem_req_q && bus.mem_ready;
    assign last_beat  = (beat_q == OFFW'(BLOCKSIZE - 1));
    assign beat_nxt   = beat_q + 1'b1;
    assign victim_tag = tag_q[victim_q][req_idx];

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_busy  = cpu_busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Next-state, registered-output and storage-update logic of the controller
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        victim_d    = victim_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = cpu_ack_q;
        cpu_busy_d  = cpu_busy_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        lru_d       = lru_q;
        dwr_en      = 1'b0;
        dwr_way     = 1'b0;
        dwr_ofs     = req_off;
        dwr_val     = req_wdata_q;
        tag_wr      = 1'b0;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req && !cpu_busy_q) begin
                    req_we_d    = bus.cpu_we;
                    req_addr_d  = bus.cpu_addr;
                    req_wdata_d = bus.cpu_wdata;
                    cpu_busy_d  = 1'b1;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit0 || hit1) begin
                    hit_evt        = 1'b1;
                    lru_d[req_idx] = ~hit_way;
                    if (req_we_q) begin
                        dwr_en                    = 1'b1;
                        dwr_way                   = hit_way;
                        dirty_d[hit_way][req_idx] = 1'b1;
                    end else begin
                        cpu_rdata_d = data_q[hit_way][req_idx][req_off];
                    end
                    cpu_ack_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    miss_evt = 1'b1;
                    victim_d = vsel;
                    beat_d   = '0;
                    state_d  = (valid_q[vsel][req_idx] && dirty_q[vsel][req_idx]) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {victim_tag, req_idx, beat_q};
                    mem_wdata_d = data_q[victim_q][req_idx][beat_q];
                end else if (beat_done) begin
                    if (last_beat) begin
                        beat_d     = '0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx, {OFFW{1'b0}}};
                        state_d    = S_FILL;
                    end else begin
                        beat_d      = beat_nxt;
                        mem_addr_d  = {victim_tag, req_idx, beat_nxt};
                        mem_wdata_d = data_q[victim_q][req_idx][beat_nxt];
                    end
                end
            end
            S_FILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_tag, req_idx, beat_q};
                end else if (beat_done) begin
                    // A write miss merges its word as that beat lands
                    dwr_en  = 1'b1;
                    dwr_way = victim_q;
                    dwr_ofs = beat_q;
                    dwr_val = (req_we_q && beat_q == req_off) ? req_wdata_q : bus.mem_rdata;
                    if (last_beat) begin
                        mem_req_d                  = 1'b0;
                        beat_d                     = '0;
                        tag_wr                     = 1'b1;
                        valid_d[victim_q][req_idx] = 1'b1;
                        dirty_d[victim_q][req_idx] = req_we_q;
                        lru_d[req_idx]             = ~victim_q;
                        if (!req_we_q) begin
                            cpu_rdata_d = (beat_q == req_off) ? bus.mem_rdata
                                                              : data_q[victim_q][req_idx][req_off];
                        end
                        cpu_ack_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = {req_tag, req_idx, beat_nxt};
                    end
                end
            end
            S_RESP: begin
                cpu_ack_d  = 1'b0;
                cpu_busy_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, bus outputs and line status bits; reset aborts any burst
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            victim_q    <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_busy_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= '{default: '0};
            dirty_q     <= '{default: '0};
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            victim_q    <= victim_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_busy_q  <= cpu_busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            lru_q       <= lru_d;
        end
    end

    // Data and tag arrays; contents are qualified by valid so need no reset
    always_ff @(posedge clock) begin
        if (dwr_en) begin
            data_q[dwr_way][req_idx][dwr_ofs] <= dwr_val;
        end
        if (tag_wr) begin
            tag_q[victim_q][req_idx] <= req_tag;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Free-running wrap-around event counters
    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, hit_evt};
        miss_count_d = miss_count_q + {31'd0, miss_evt};
    end

    // Counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_evt;
    assign unused_evt = hit_evt | miss_evt;
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_2way_wb.sv
// Directed bench for cache_2way_wb (AWIDTH=16, DWIDTH=8, BLOCKSIZE=4,
// NUMSETS=16). Memory word at address a holds ((a*7+3) mod 256) ^ a[15:8]
// until written back; it returns 0xEE while mem_ready is low.
module tb_cache_2way_wb;
    logic        clock;
    logic        reset_n;
    logic [31:0] hit_count, miss_count;

    cache_2way_wb_if #(.AWIDTH(16), .DWIDTH(8)) bus ();

    cache_2way_wb #(.AWIDTH(16), .DWIDTH(8), .BLOCKSIZE(4), .NUMSETS(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model and beat log
    logic [7:0]  wmem    [65536];
    bit          written [65536];
    logic [15:0] log_addr [256];
    logic        log_we   [256];
    logic [7:0]  log_data [256];
    int          log_n = 0;
    logic        rdy = 1'b1;
    int          stall_arm = 0, stall_done = 0, stall_left = 0, stall_bad = 0;
    logic [15:0] stall_addr;

    function automatic logic [7:0] pat(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'd7 + 16'd3;
        return p[7:0] ^ a[15:8];
    endfunction

    assign bus.mem_ready = rdy;
    assign bus.mem_rdata = !rdy ? 8'hEE :
                           (written[bus.mem_addr] ? wmem[bus.mem_addr] : pat(bus.mem_addr));

    always @(posedge clock) begin
        if (bus.mem_req && bus.mem_ready) begin
            if (log_n < 256) begin
                log_addr[log_n] <= bus.mem_addr;
                log_we[log_n]   <= bus.mem_we;
                log_data[log_n] <= bus.mem_we ? bus.mem_wdata : bus.mem_rdata;
            end
            if (bus.mem_we) begin
                wmem[bus.mem_addr]    <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end
            log_n <= log_n + 1;
        end
    end

    // Three-cycle back-pressure on fill beat 2 when armed
    always @(negedge clock) begin
        if (stall_left > 0) begin
            if (bus.mem_addr !== stall_addr || bus.mem_req !== 1'b1) stall_bad++;
            stall_left--;
            if (stall_left == 0) rdy = 1'b1;
        end else if (stall_arm != stall_done && bus.mem_req && !bus.mem_we &&
                     bus.mem_addr[1:0] == 2'd2) begin
            stall_done++;
            stall_left = 3;
            stall_addr = bus.mem_addr;
            rdy        = 1'b0;
        end
    end

    logic busy_seen;
    int   beat_base;

    task automatic do_req(input logic we, input logic [15:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat, output int nbeats);
        int start;
        @(negedge clock);
        start         = log_n;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        bus.cpu_req = 1'b0;
        busy_seen   = bus.cpu_busy;
        lat = 1;
        while (bus.cpu_ack !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (bus.cpu_ack !== 1'b1) check("ack_timeout", 32'd0, 32'd1);
        rd        = bus.cpu_rdata;
        beat_base = start;
        nbeats    = log_n - start;
    endtask

    logic [7:0]  rd;
    int          lat, nb, guard;
    logic [7:0]  wb_exp [4];

    initial begin
        reset_n       = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(negedge clock);
        check("rst_ack",   {31'd0, bus.cpu_ack},  32'd0);
        check("rst_busy",  {31'd0, bus.cpu_busy}, 32'd0);
        check("rst_memreq",{31'd0, bus.mem_req},  32'd0);
        check("rst_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        check("rst_maddr", {16'd0, bus.mem_addr}, 32'd0);
        check("rst_hits",  hit_count,  32'd0);
        check("rst_miss",  miss_count, 32'd0);
        reset_n = 1'b1;

        // Cold read miss: four fill beats 0x10..0x13, ack 7 cycles after acceptance
        do_req(1'b0, 16'h0012, 8'h00, rd, lat, nb);
        check("cold_busy",  {31'd0, busy_seen}, 32'd1);
        check("cold_lat",   lat, 7);
        check("cold_rdata", {24'd0, rd}, 32'h81);
        check("cold_beats", nb, 4);
        for (int i = 0; i < 4; i++) begin
            check("cold_baddr", {16'd0, log_addr[beat_base+i]}, 32'h10 + i);
            check("cold_bwe",   {31'd0, log_we[beat_base+i]}, 32'd0);
        end

        // Repeat read: hit
        do_req(1'b0, 16'h0012, 8'h00, rd, lat, nb);
        check("hit_lat",   lat, 2);
        check("hit_rdata", {24'd0, rd}, 32'h81);
        check("hit_beats", nb, 0);
`ifdef CACHE_PERF_CNT_EN
        check("cnt_hit",  hit_count,  32'd1);
        check("cnt_miss", miss_count, 32'd1);
`else
        check("cnt_hit",  hit_count,  32'd0);
        check("cnt_miss", miss_count, 32'd0);
`endif

        // Write hit then back-to-back read of the same word
        do_req(1'b1, 16'h0011, 8'hA5, rd, lat, nb);
        check("wr_lat",   lat, 2);
        check("wr_beats", nb, 0);
        do_req(1'b0, 16'h0011, 8'h00, rd, lat, nb);
        check("rdw_lat",   lat, 2);
        check("rdw_rdata", {24'd0, rd}, 32'hA5);

        // Second way of set 4 gets 0x0110; then touch 0x0012 so 0x0110 is LRU
        do_req(1'b0, 16'h0110, 8'h00, rd, lat, nb);
        check("w1_lat",   lat, 7);
        check("w1_rdata", {24'd0, rd}, 32'h72);
        do_req(1'b0, 16'h0012, 8'h00, rd, lat, nb);
        check("touch_lat", lat, 2);

        // 0x0210 evicts the clean 0x0110 way: no write-back
        do_req(1'b0, 16'h0210, 8'h00, rd, lat, nb);
        check("clean_lat",   lat, 7);
        check("clean_beats", nb, 4);
        check("clean_rdata", {24'd0, rd}, 32'h71);
        check("clean_we0",   {31'd0, log_we[beat_base]}, 32'd0);
        check("clean_addr0", {16'd0, log_addr[beat_base]}, 32'h210);

        // 0x0310 evicts the dirty 0x0010 line: write-back then fill
        wb_exp = '{8'h73, 8'hA5, 8'h81, 8'h88};
        do_req(1'b0, 16'h0310, 8'h00, rd, lat, nb);
        check("dirty_lat",   lat, 11);
        check("dirty_beats", nb, 8);
        check("dirty_rdata", {24'd0, rd}, 32'h70);
        for (int i = 0; i < 4; i++) begin
            check("wb_addr", {16'd0, log_addr[beat_base+i]}, 32'h10 + i);
            check("wb_we",   {31'd0, log_we[beat_base+i]}, 32'd1);
            check("wb_data", {24'd0, log_data[beat_base+i]}, {24'd0, wb_exp[i]});
        end
        check("df_addr0", {16'd0, log_addr[beat_base+4]}, 32'h310);
        check("df_we0",   {31'd0, log_we[beat_base+4]}, 32'd0);

        // Back-pressure on fill beat 2: address held, beat not taken early
        stall_arm = stall_arm + 1;
        do_req(1'b0, 16'h0412, 8'h00, rd, lat, nb);
        check("stall_lat",   lat, 10);
        check("stall_rdata", {24'd0, rd}, 32'h85);
        check("stall_beats", nb, 4);
        check("stall_hold",  stall_bad, 0);
        check("stall_done",  stall_done, 1);

        // Reset during fill beat 2, then the same read misses again
        @(negedge clock);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0512;
        @(posedge clock);
        @(negedge clock);
        bus.cpu_req = 1'b0;
        guard = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h0512) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("rst_reach", {31'd0, bus.mem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstm_memreq", {31'd0, bus.mem_req},  32'd0);
        check("rstm_busy",   {31'd0, bus.cpu_busy}, 32'd0);
        check("rstm_maddr",  {16'd0, bus.mem_addr}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        do_req(1'b0, 16'h0512, 8'h00, rd, lat, nb);
        check("rerd_lat",   lat, 7);
        check("rerd_beats", nb, 4);
        check("rerd_rdata", {24'd0, rd}, 32'h84);
        do_req(1'b0, 16'h0012, 8'h00, rd, lat, nb);
        check("cleared_lat", lat, 7);
`ifdef CACHE_PERF_CNT_EN
        check("cnt_miss2", miss_count, 32'd2);
        check("cnt_hit2",  hit_count,  32'd0);
`else
        check("cnt_miss2", miss_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
